// File: rtl/ppc_types_pkg.sv
// Shared PowerPC type definitions: SPR numbers and the supported-SPR check
// used by units that write the special-purpose register file.
package ppc_types;

  localparam int unsigned SPR_ADDR_W = 10;
  localparam int unsigned SPR_DATA_W = 32;

  localparam logic [SPR_ADDR_W-1:0] SPR_XER = 10'd1;
  localparam logic [SPR_ADDR_W-1:0] SPR_LR  = 10'd8;
  localparam logic [SPR_ADDR_W-1:0] SPR_CTR = 10'd9;

  function automatic logic spr_supported(input logic [SPR_ADDR_W-1:0] addr);
    return (addr == SPR_XER) || (addr == SPR_LR) || (addr == SPR_CTR);
  endfunction

endpackage

// File: rtl/spr_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N. Shared with future issue arbiters.
module rr_picker #(
  parameter  int unsigned N     = 3,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(ptr) + k) % N);
      if (!any_grant && request[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/spr_write_arbiter.sv
// Shares the SPR file write port between several result producers: one
// holding buffer per requester, round-robin selection, registered write.
module spr_write_arbiter
  import ppc_types::*;
#(
  parameter  int unsigned REQUESTERS  = 3,
  parameter  int unsigned RS_ID_WIDTH = 5,
  localparam int unsigned SRC_W       = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   req_valid [REQUESTERS],
  output logic                   req_ready [REQUESTERS],
  input  logic [SPR_ADDR_W-1:0]  req_addr  [REQUESTERS],
  input  logic [SPR_DATA_W-1:0]  req_value [REQUESTERS],
  input  logic [RS_ID_WIDTH-1:0] req_rs_id [REQUESTERS],
  output logic [SPR_ADDR_W-1:0]  write_addr,
  output logic                   write_enable,
  output logic [SPR_DATA_W-1:0]  write_value,
  output logic [RS_ID_WIDTH-1:0] write_rs_id,
  output logic                   addr_error,
  output logic [SRC_W-1:0]       addr_error_src
);

  typedef struct packed {
    logic [SPR_ADDR_W-1:0]  addr;
    logic [SPR_DATA_W-1:0]  value;
    logic [RS_ID_WIDTH-1:0] rs_id;
  } entry_t;

  entry_t                  buf_q [REQUESTERS];
  logic [REQUESTERS-1:0]   buf_valid;
  logic [SRC_W-1:0]        ptr;

  logic [REQUESTERS-1:0]   grant;
  logic [SRC_W-1:0]        grant_idx;
  logic                    any_grant;

  logic [REQUESTERS-1:0]   accept_c;
  logic [REQUESTERS-1:0]   load_c;
  logic                    err_c;
  logic [SRC_W-1:0]        err_idx_c;

  rr_picker #(.N(REQUESTERS)) u_picker (
    .request   (buf_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A buffer being drained this cycle can take a new result in the same cycle.
  // Descending scan so the lowest erring requester is the one reported.
  always_comb begin
    accept_c  = '0;
    load_c    = '0;
    err_c     = 1'b0;
    err_idx_c = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      req_ready[i] = !rst && !flush && (!buf_valid[i] || grant[i]);
      accept_c[i]  = req_valid[i] && req_ready[i];
      load_c[i]    = accept_c[i] && spr_supported(req_addr[i]);
      if (accept_c[i] && !spr_supported(req_addr[i])) begin
        err_c     = 1'b1;
        err_idx_c = SRC_W'(i);
      end
    end
  end

  // Payload only matters while buf_valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQUESTERS; i++) begin
      if (load_c[i]) begin
        buf_q[i] <= '{addr: req_addr[i], value: req_value[i], rs_id: req_rs_id[i]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid      <= '0;
      ptr            <= '0;
      write_enable   <= 1'b0;
      write_addr     <= '0;
      write_value    <= '0;
      write_rs_id    <= '0;
      addr_error     <= 1'b0;
      addr_error_src <= '0;
    end else if (flush) begin
      buf_valid    <= '0;
      write_enable <= 1'b0;
      addr_error   <= 1'b0;
    end else begin
      write_enable <= any_grant;
      if (any_grant) begin
        write_addr  <= buf_q[grant_idx].addr;
        write_value <= buf_q[grant_idx].value;
        write_rs_id <= buf_q[grant_idx].rs_id;
        ptr         <= (grant_idx == SRC_W'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
      end
      addr_error <= err_c;
      if (err_c) begin
        addr_error_src <= err_idx_c;
      end
      for (int i = 0; i < REQUESTERS; i++) begin
        if (load_c[i]) begin
          buf_valid[i] <= 1'b1;
        end else if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spr_write_arbiter.sv
// Bench for spr_write_arbiter: directed vector table, a saturation sequence
// and randomized traffic against a behavioural reference model.
module tb_spr_write_arbiter;

  localparam int N   = 3;
  localparam int RSW = 5;

  logic           clk;
  logic           rst;
  logic           flush;
  logic           req_valid [N];
  logic           req_ready [N];
  logic [9:0]     req_addr  [N];
  logic [31:0]    req_value [N];
  logic [RSW-1:0] req_rs_id [N];
  logic [9:0]     write_addr;
  logic           write_enable;
  logic [31:0]    write_value;
  logic [RSW-1:0] write_rs_id;
  logic           addr_error;
  logic [1:0]     addr_error_src;

  spr_write_arbiter #(.REQUESTERS(N), .RS_ID_WIDTH(RSW)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_value      (req_value),
    .req_rs_id      (req_rs_id),
    .write_addr     (write_addr),
    .write_enable   (write_enable),
    .write_value    (write_value),
    .write_rs_id    (write_rs_id),
    .addr_error     (addr_error),
    .addr_error_src (addr_error_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending result per requester, rotating priority pointer.
  bit          m_bv   [N];
  logic [9:0]  m_ba   [N];
  logic [31:0] m_bval [N];
  logic [4:0]  m_bid  [N];
  int          m_ptr;
  bit          m_we;
  logic [9:0]  m_wa;
  logic [31:0] m_wv;
  logic [4:0]  m_wid;
  bit          m_err;
  int          m_esrc;
  logic [2:0]  m_rdy;
  logic [2:0]  rdy_s;

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step(input bit cmp);
    int g;
    bit hs [N];
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (g < 0 && m_bv[j]) g = j;
    end
    for (int i = 0; i < N; i++) begin
      m_rdy[i] = !rst && !flush && (!m_bv[i] || g == i);
      rdy_s[i] = req_ready[i];
      hs[i]    = req_valid[i] && m_rdy[i];
    end
    if (cmp) chk("model req_ready", 64'(rdy_s), 64'(m_rdy));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < N; i++) m_bv[i] = 0;
      m_ptr = 0; m_we = 0; m_wa = '0; m_wv = '0; m_wid = '0; m_err = 0; m_esrc = 0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) m_bv[i] = 0;
      m_we = 0; m_err = 0;
    end else begin
      if (g >= 0) begin
        m_we = 1; m_wa = m_ba[g]; m_wv = m_bval[g]; m_wid = m_bid[g];
        m_bv[g] = 0;
        m_ptr = (g + 1) % N;
      end else begin
        m_we = 0;
      end
      m_err = 0;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          if (req_addr[i] inside {10'd1, 10'd8, 10'd9}) begin
            m_bv[i] = 1; m_ba[i] = req_addr[i]; m_bval[i] = req_value[i]; m_bid[i] = req_rs_id[i];
          end else if (!m_err) begin
            m_err = 1; m_esrc = i;
          end
        end
      end
    end
    #1;
    if (cmp) begin
      chk("model write_enable", 64'(write_enable), 64'(m_we));
      if (m_we) begin
        chk("model write_addr", 64'(write_addr), 64'(m_wa));
        chk("model write_value", 64'(write_value), 64'(m_wv));
        chk("model write_rs_id", 64'(write_rs_id), 64'(m_wid));
      end
      chk("model addr_error", 64'(addr_error), 64'(m_err));
      if (m_err) chk("model addr_error_src", 64'(addr_error_src), 64'(m_esrc));
    end
  endtask

  typedef struct {
    logic        rst, flush;
    logic [2:0]  valid;
    logic [9:0]  a0, a1, a2;
    logic [31:0] val;
    logic [4:0]  id;
    logic [2:0]  er;
    logic        ewe;
    logic [9:0]  ewa;
    logic [31:0] ewv;
    logic [4:0]  ewid;
    logic        eerr;
    logic [1:0]  esrc;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [31:0] r, f, v, a0, a1, a2, val, id,
                              er, ewe, ewa, ewv, ewid, eerr, esrc);
    vec_t t;
    t.rst = r[0]; t.flush = f[0]; t.valid = 3'(v);
    t.a0 = 10'(a0); t.a1 = 10'(a1); t.a2 = 10'(a2);
    t.val = val; t.id = 5'(id); t.er = 3'(er);
    t.ewe = ewe[0]; t.ewa = 10'(ewa); t.ewv = ewv; t.ewid = 5'(ewid);
    t.eerr = eerr[0]; t.esrc = 2'(esrc);
    return t;
  endfunction

  function automatic vec_t idle(input logic [31:0] er, ewe, ewa, ewv, ewid);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, er, ewe, ewa, ewv, ewid, 0, 0);
  endfunction

  logic [9:0] sat_addr [N];

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0; req_addr[i] = '0; req_value[i] = '0; req_rs_id[i] = '0;
    end

    // Columns: rst flush valid a0 a1 a2 value id | ready we waddr wvalue wid err src
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8, 0, 0, 'hDEADBEEF, 3,        7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(7, 1, 8, 'hDEADBEEF, 3));
    tbl.push_back(idle(7, 0, 8, 'hDEADBEEF, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 7, 1, 8, 9, 'h100, 7,             7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 'h100, 7));
    tbl.push_back(idle(3, 1, 8, 'h100, 7));
    tbl.push_back(idle(7, 1, 9, 'h100, 7));
    tbl.push_back(idle(7, 0, 9, 'h100, 7));
    tbl.push_back(mk(0, 0, 6, 0, 9, 1, 'h200, 4,             7, 0, 9, 'h100, 7, 0, 0));
    tbl.push_back(idle(3, 1, 9, 'h200, 4));
    tbl.push_back(idle(7, 1, 1, 'h200, 4));
    tbl.push_back(idle(7, 0, 1, 'h200, 4));
    tbl.push_back(mk(0, 0, 4, 0, 0, 9, 1, 2,                 7, 0, 1, 'h200, 4, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 9, 2, 2,                 7, 1, 9, 1, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 9, 3, 2,                 7, 1, 9, 2, 2, 0, 0));
    tbl.push_back(mk(0, 0, 4, 0, 0, 9, 4, 2,                 7, 1, 9, 3, 2, 0, 0));
    tbl.push_back(idle(7, 1, 9, 4, 2));
    tbl.push_back(idle(7, 0, 9, 4, 2));
    tbl.push_back(mk(0, 0, 2, 0, 5, 0, 'h55, 1,              7, 0, 9, 4, 2, 1, 1));
    tbl.push_back(idle(7, 0, 9, 4, 2));
    tbl.push_back(mk(0, 0, 3, 8, 1, 0, 'h77, 9,              7, 0, 9, 4, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,                 0, 0, 9, 4, 2, 0, 0));
    tbl.push_back(idle(7, 0, 9, 4, 2));
    tbl.push_back(idle(7, 0, 9, 4, 2));
    tbl.push_back(mk(0, 0, 7, 1, 8, 9, 'h300, 5,             7, 0, 9, 4, 2, 0, 0));
    tbl.push_back(idle(1, 1, 1, 'h300, 5));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,                 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 7, 1, 8, 9, 'h400, 6,             7, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle(1, 1, 1, 'h400, 6));
    tbl.push_back(idle(3, 1, 8, 'h400, 6));
    tbl.push_back(idle(7, 1, 9, 'h400, 6));
    tbl.push_back(idle(7, 0, 9, 'h400, 6));

    @(posedge clk);
    #1;

    foreach (tbl[n]) begin
      rst = tbl[n].rst;
      flush = tbl[n].flush;
      req_addr[0] = tbl[n].a0; req_addr[1] = tbl[n].a1; req_addr[2] = tbl[n].a2;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = tbl[n].valid[i];
        req_value[i] = tbl[n].val;
        req_rs_id[i] = tbl[n].id;
      end
      step(1'b0);
      chk($sformatf("row%0d req_ready", n), 64'(rdy_s), 64'(tbl[n].er));
      chk($sformatf("row%0d write_enable", n), 64'(write_enable), 64'(tbl[n].ewe));
      chk($sformatf("row%0d write_addr", n), 64'(write_addr), 64'(tbl[n].ewa));
      chk($sformatf("row%0d write_value", n), 64'(write_value), 64'(tbl[n].ewv));
      chk($sformatf("row%0d write_rs_id", n), 64'(write_rs_id), 64'(tbl[n].ewid));
      chk($sformatf("row%0d addr_error", n), 64'(addr_error), 64'(tbl[n].eerr));
      if (tbl[n].eerr) chk($sformatf("row%0d addr_error_src", n), 64'(addr_error_src), 64'(tbl[n].esrc));
    end

    // Saturation: all requesters always valid; grants must rotate 0,1,2 every cycle.
    sat_addr[0] = 10'd1; sat_addr[1] = 10'd8; sat_addr[2] = 10'd9;
    rst = 1'b1;
    for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
    step(1'b1);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b1; req_addr[i] = sat_addr[i]; req_value[i] = 32'(i + 16); req_rs_id[i] = 5'(i);
    end
    for (int k = 0; k < 13; k++) begin
      step(1'b1);
      if (k == 0) begin
        chk("sat first write_enable", 64'(write_enable), 64'(0));
      end else begin
        chk($sformatf("sat%0d write_enable", k), 64'(write_enable), 64'(1));
        chk($sformatf("sat%0d write_addr", k), 64'(write_addr), 64'(sat_addr[(k - 1) % N]));
      end
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(0, 127) == 0);
      flush = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 7))
          0:       req_addr[i] = 10'd1;
          1:       req_addr[i] = 10'd8;
          2, 3:    req_addr[i] = 10'd9;
          4:       req_addr[i] = 10'd5;
          5:       req_addr[i] = 10'd0;
          default: req_addr[i] = 10'($urandom_range(0, 1023));
        endcase
        req_value[i] = $urandom;
        req_rs_id[i] = 5'($urandom_range(0, 31));
      end
      step(1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spr_write_arbiter.md
Name: spr_write_arbiter

Overview:
Shares the single write port of the special-purpose register file (XER, LR, CTR) between several result-producing units. Each requester gets a 1-entry holding buffer with a valid/ready handshake. A round-robin arbiter picks one buffered result per cycle and drives a registered write transaction into the SPR file. Requests to unsupported SPR addresses are dropped and flagged.

Parameters:
REQUESTERS, 3, number of result sources (integer ALU, branch unit, load/store); minimum 2.
RS_ID_WIDTH, 5, width of the reservation-station ID; must match the SPR file.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
flush  input  1  synchronous pipeline flush; discards all buffered results
req_valid[0:REQUESTERS-1]  input  1 each  requester i presents a result
req_ready[0:REQUESTERS-1]  output  1 each  requester i's buffer can accept
req_addr[0:REQUESTERS-1]  input  10 each  SPR number
req_value[0:REQUESTERS-1]  input  32 each  result value
req_rs_id[0:REQUESTERS-1]  input  RS_ID_WIDTH each  producing reservation-station ID
write_addr  output  10  to SPR file write port
write_enable  output  1  to SPR file write port
write_value  output  32  to SPR file write port
write_rs_id  output  RS_ID_WIDTH  to SPR file write port
addr_error  output  1  one-cycle pulse: a request to an unsupported SPR was dropped
addr_error_src  output  $clog2(REQUESTERS)  requester index for addr_error

Behaviour:
- Reset (rst=1 at posedge):
  - All buffers empty; round-robin pointer = 0.
  - write_enable=0, write_addr=0, write_value=0, write_rs_id=0.
  - addr_error=0, addr_error_src=0.
  - req_ready forced to 0 while rst is high.
- Per-requester state: buf_valid and buf {addr, value, rs_id}.
- req_ready[i] = !rst && !flush && (!buf_valid[i] || grant[i]).
  - Depends only on state and the grant; never on req_valid.
  - A handshake is req_valid[i] && req_ready[i] at posedge.
- Accept, supported address (1, 8 or 9): buffer loads the request; buf_valid=1.
- Accept, any other address:
  - Request is consumed but not buffered.
  - Next cycle addr_error=1 and addr_error_src=i.
  - If several requesters err in the same cycle, the lowest index is reported; the others are dropped silently.
- Arbitration (combinational, each cycle):
  - grant = first buf_valid[j], scanning j = ptr, ptr+1, … modulo REQUESTERS.
  - At most one grant.
- Grant edge:
  - Output registers load the granted buffer; write_enable=1 for exactly one cycle per grant.
  - Granted buffer clears, unless the same requester handshakes in that cycle; then it reloads with the new request.
  - ptr <= granted index + 1, wrapping from REQUESTERS-1 to 0.
- No grant: write_enable=0; other output fields hold their last value; ptr unchanged.
- Latency: handshake at edge T, write_enable high in the cycle after edge T+1 (2 cycles), when uncontested.
- Throughput:
  - One write per cycle aggregate.
  - An uncontested requester sustains one result per cycle.
  - With N requesters all busy, each is granted once every N cycles (starvation-free).
- Flush (flush=1 at posedge):
  - All buffers cleared; write_enable=0 next cycle.
  - No handshakes accepted; addr_error=0.
  - ptr unchanged.
- Ordering:
  - No ordering is guaranteed between requesters writing the same SPR.
  - Stale writes are rejected by the SPR file's rs_id match, not here.
- Rst or flush mid-transaction: the in-flight registered write is dropped (write_enable=0 next cycle).

Decomposition:
- Shared package ppc_types:
  - Constants SPR_XER=10'd1, SPR_LR=10'd8, SPR_CTR=10'd9.
  - Function spr_supported(addr) returning 1 for those three.
- Buffer struct stays local, because it depends on RS_ID_WIDTH.
- Sub-module rr_picker (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational; reusable by later issue arbiters.

Test Plan:
- Single request: requester 0, addr 8, value 0xDEADBEEF, rs_id 3 at edge T -> write_enable=1 with addr 8, value 0xDEADBEEF, rs_id 3 after edge T+1, for exactly 1 cycle.
- Contention: all 3 requesters valid together (addr 1, 8, 9) from reset -> writes emitted in order 0, 1, 2 on consecutive cycles. Then requesters 1 and 2 re-request while 0 is idle -> order 1, 2 (ptr continues).
- Back-to-back: requester 2 streams 4 CTR writes with values 1..4, others idle -> req_ready[2] stays high; write_enable high 4 consecutive cycles carrying 1, 2, 3, 4.
- Bad address: requester 1 sends addr 5 -> handshake completes; addr_error=1 with addr_error_src=1 next cycle; no write_enable ever issued for it.
- Flush: requesters 0 and 1 buffered, flush asserted -> next cycle write_enable=0, req_ready high for both; no stale write appears later.
- Reset mid-stream: rst during a granted cycle -> next cycle all outputs 0 and req_ready=0; after rst deasserts, ptr=0, so requester 0 wins the first contention.
